gmsk_demodulate: RTL and testbench
==================================

GMSK_DEMODULATE -- requirements
Module: gmsk_demodulate

Parameters
REQ-001 SHALL have parameter SPS, default 4, samples per symbol; legal values 2..16.
REQ-002 SHALL have parameter BURST_BITS, default 148, bits decoded per burst.
REQ-003 SHALL have parameter ENERGY_THRESH, default 64, 9-bit unsigned magnitude threshold.
REQ-004 SHALL have parameter ENERGY_RUN, default 8, consecutive above-threshold samples needed to declare a burst.

Interface
REQ-005 SHALL have port clock, input, 1, the single clock; all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have port in_i, input, 8, signed two's-complement I sample.
REQ-008 SHALL have port in_q, input, 8, signed two's-complement Q sample.
REQ-009 SHALL have port sample_valid, input, 1, in_i/in_q qualified this cycle.
REQ-010 SHALL have port rx_enable, input, 1, level; receiver armed while high.
REQ-011 SHALL have port bit_out, output, 1, decided bit.
REQ-012 SHALL have port bit_valid, output, 1, one-cycle strobe qualifying bit_out.
REQ-013 SHALL have port burst_active, output, 1, high while in DATA.
REQ-014 SHALL have port burst_done, output, 1, one-cycle pulse after the last bit of a complete burst.
REQ-015 SHALL have port bit_count, output, 8, bits decoded in the current or last burst.

Function
REQ-016 SHALL implement states IDLE, SEARCH, DATA, DONE; all outputs registered.
REQ-017 IDLE: if rx_enable=1 -> SEARCH next cycle; otherwise remain, ignoring samples.
REQ-018 Magnitude SHALL be |in_i|+|in_q| as 9-bit unsigned; |-128|=128, so the maximum is 256.
REQ-019 SEARCH, per valid sample: magnitude > ENERGY_THRESH -> run counter +1; otherwise run counter = 0; samples with sample_valid=0 leave it unchanged.
REQ-020 When the run counter reaches ENERGY_RUN -> DATA; clear the phase counter, accumulator and bit_count.
REQ-021 The prev_i/prev_q registers SHALL capture every valid sample in SEARCH and DATA, so the first DATA product uses the last SEARCH sample.
REQ-022 DATA, per valid sample: cross = prev_i*in_q - prev_q*in_i, 17-bit signed, full precision, no saturation.
REQ-023 The accumulator SHALL be a 21-bit signed integrate-and-dump, adding cross on each valid sample.
REQ-024 On the SPS-th valid sample of a symbol, bit_out = 1 if (accumulator+cross) >= 0, else 0.
REQ-025 On that same sample: bit_valid=1 for exactly one cycle, accumulator cleared, bit_count +1.
REQ-026 Latency: bit_valid is asserted on the cycle after the edge that samples the SPS-th valid sample.
REQ-027 When bit_count reaches BURST_BITS -> DONE; DONE asserts burst_done for one cycle, then -> SEARCH if rx_enable=1, else -> IDLE.
REQ-028 rx_enable=0 in SEARCH or DATA SHALL abort to IDLE on the next edge: no burst_done, no further bit_valid, bit_count holds its value.
REQ-029 sample_valid gaps in DATA SHALL stall the phase counter and accumulator without loss.
REQ-030 burst_active SHALL be 1 exactly while in DATA; bit_valid and burst_done are 0 in every other state.
REQ-031 bit_count SHALL hold its final value until the next entry into DATA.

Reset
REQ-032 reset=1 SHALL force IDLE and clear bit_out, bit_valid, burst_active, burst_done, bit_count, accumulator, all counters and prev_i/prev_q to 0.
REQ-033 reset SHALL take priority over every other input, including mid-burst.

Verification
REQ-034 Constant-CCW rotation, 90 deg/symbol, amplitude 100, SPS=4, rx_enable=1 -> burst_active after 8 samples; 148 bit_valid pulses all with bit_out=1; one burst_done; bit_count=148.
REQ-035 CW rotation, same setup -> all 148 bits are 0.
REQ-036 Amplitude-20 tone (magnitude <= 40 < 64) for 1000 samples -> never leaves SEARCH; no bit_valid.
REQ-037 Alternating bit pattern with sample_valid low every other cycle -> identical bit sequence and bit_count as the gap-free run.
REQ-038 rx_enable dropped after 50 bits -> IDLE next cycle; no burst_done; bit_count=50.
REQ-039 reset pulsed after 10 bits -> all outputs 0 next cycle; a new burst decodes normally.

Source files
------------

// File: rtl/gmsk_demodulate.sv
`default_nettype none
// ============================================================================
//  Module      : gmsk_demodulate
//  Description : Burst GMSK receiver. Energy-run burst detection followed by
//                a differential (cross-product) discriminator with
//                integrate-and-dump bit decisions.
//  Revision    : 1.0 - initial release
// ============================================================================
module gmsk_demodulate #(
    parameter int SPS           = 4,
    parameter int BURST_BITS    = 148,
    parameter int ENERGY_THRESH = 64,
    parameter int ENERGY_RUN    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic signed [7:0] in_i,
    input  logic signed [7:0] in_q,
    input  logic              sample_valid,
    input  logic              rx_enable,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              burst_active,
    output logic              burst_done,
    output logic [7:0]        bit_count
);

    localparam int c_PW = $clog2(SPS);
    localparam int c_RW = $clog2(ENERGY_RUN + 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SEARCH = 2'd1;
    localparam logic [1:0] c_DATA   = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam logic [8:0]      c_THRESH     = 9'(ENERGY_THRESH);
    localparam logic [c_RW-1:0] c_RUN_LAST   = c_RW'(ENERGY_RUN - 1);
    localparam logic [c_PW-1:0] c_PHASE_LAST = c_PW'(SPS - 1);
    localparam logic [7:0]      c_COUNT_LAST = 8'(BURST_BITS - 1);

    logic [1:0]         r_state;
    logic [c_RW-1:0]    r_run;
    logic [c_PW-1:0]    r_phase;
    logic signed [20:0] r_acc;
    logic signed [7:0]  r_prev_i;
    logic signed [7:0]  r_prev_q;

    logic [7:0]         w_abs_i;
    logic [7:0]         w_abs_q;
    logic [8:0]         w_mag;
    logic               w_above;
    logic signed [16:0] w_pi;
    logic signed [16:0] w_pq;
    logic signed [16:0] w_ci;
    logic signed [16:0] w_cq;
    logic signed [16:0] w_cross;
    logic signed [20:0] w_sum;

    // |-128| wraps to 8'h80, which reads as 128 unsigned
    assign w_abs_i = in_i[7] ? (~$unsigned(in_i) + 8'd1) : $unsigned(in_i);
    assign w_abs_q = in_q[7] ? (~$unsigned(in_q) + 8'd1) : $unsigned(in_q);
    assign w_mag   = {1'b0, w_abs_i} + {1'b0, w_abs_q};
    assign w_above = (w_mag > c_THRESH);

    assign w_pi    = $signed({{9{r_prev_i[7]}}, r_prev_i});
    assign w_pq    = $signed({{9{r_prev_q[7]}}, r_prev_q});
    assign w_ci    = $signed({{9{in_i[7]}}, in_i});
    assign w_cq    = $signed({{9{in_q[7]}}, in_q});
    assign w_cross = (w_pi * w_cq) - (w_pq * w_ci);
    assign w_sum   = r_acc + $signed({{4{w_cross[16]}}, w_cross});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_run        <= '0;
            r_phase      <= '0;
            r_acc        <= '0;
            r_prev_i     <= '0;
            r_prev_q     <= '0;
            bit_out      <= 1'b0;
            bit_valid    <= 1'b0;
            burst_active <= 1'b0;
            burst_done   <= 1'b0;
            bit_count    <= '0;
        end else begin
            bit_valid  <= 1'b0;
            burst_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_run <= '0;
                    if (rx_enable) r_state <= c_SEARCH;
                end
                c_SEARCH: begin
                    if (!rx_enable) begin
                        r_state <= c_IDLE;
                    end else if (sample_valid) begin
                        r_prev_i <= in_i;
                        r_prev_q <= in_q;
                        if (!w_above) begin
                            r_run <= '0;
                        end else if (r_run == c_RUN_LAST) begin
                            r_run        <= '0;
                            r_phase      <= '0;
                            r_acc        <= '0;
                            bit_count    <= '0;
                            burst_active <= 1'b1;
                            r_state      <= c_DATA;
                        end else begin
                            r_run <= r_run + 1'b1;
                        end
                    end
                end
                c_DATA: begin
                    if (!rx_enable) begin
                        burst_active <= 1'b0;
                        r_state      <= c_IDLE;
                    end else if (sample_valid) begin
                        r_prev_i <= in_i;
                        r_prev_q <= in_q;
                        if (r_phase == c_PHASE_LAST) begin
                            // decision includes the symbol's final product
                            bit_out   <= ~w_sum[20];
                            bit_valid <= 1'b1;
                            r_acc     <= '0;
                            r_phase   <= '0;
                            bit_count <= bit_count + 8'd1;
                            if (bit_count == c_COUNT_LAST) begin
                                burst_active <= 1'b0;
                                burst_done   <= 1'b1;
                                r_state      <= c_DONE;
                            end
                        end else begin
                            r_acc   <= w_sum;
                            r_phase <= r_phase + 1'b1;
                        end
                    end
                end
                c_DONE: begin
                    r_run   <= '0;
                    r_state <= rx_enable ? c_SEARCH : c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gmsk_demodulate.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gmsk_demodulate
//  Description : Self-checking bench for gmsk_demodulate against a
//                sample-list reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gmsk_demodulate;

    localparam int c_SPS    = 4;
    localparam int c_BITS   = 148;
    localparam int c_THRESH = 64;
    localparam int c_RUN    = 8;
    localparam real c_PI    = 3.14159265358979;

    logic              clock = 1'b0;
    logic              reset;
    logic signed [7:0] in_i;
    logic signed [7:0] in_q;
    logic              sample_valid;
    logic              rx_enable;
    logic              bit_out;
    logic              bit_valid;
    logic              burst_active;
    logic              burst_done;
    logic [7:0]        bit_count;

    int errors = 0;
    int checks = 0;
    int si[$];
    int sq[$];
    bit got[$];
    bit exp_bits[$];
    int exp_det;
    int n_done;
    int n_fed;
    int first_active;

    gmsk_demodulate #(
        .SPS          (c_SPS),
        .BURST_BITS   (c_BITS),
        .ENERGY_THRESH(c_THRESH),
        .ENERGY_RUN   (c_RUN)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_i        (in_i),
        .in_q        (in_q),
        .sample_valid(sample_valid),
        .rx_enable   (rx_enable),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .burst_active(burst_active),
        .burst_done  (burst_done),
        .bit_count   (bit_count)
    );

    always #5 clock = ~clock;

    // Advance one clock and record outputs just after the edge
    task automatic step();
        @(posedge clock);
        #1;
        if (bit_valid) got.push_back(bit_out);
        if (burst_done) n_done++;
        if (burst_active && first_active < 0) first_active = n_fed;
    endtask

    task automatic feed(input int i, input int q, input bit v);
        in_i = 8'(i);
        in_q = 8'(q);
        sample_valid = v;
        if (v) n_fed++;
        step();
    endtask

    // mode: 0 CCW, 1 CW, 2 alternating symbols, 3 random symbols
    task automatic gen_burst(input int mode, input int amp, input int n_samp);
        real ph;
        real step_rad;
        int  dir;
        int  k;
        si.delete();
        sq.delete();
        step_rad = (c_PI / 2.0) / c_SPS;
        ph = $urandom_range(0, 359) * c_PI / 180.0;
        for (int n = 0; n < n_samp; n++) begin
            if (n > 0) begin
                k = (n - c_RUN) / c_SPS;
                case (mode)
                    0: dir = 1;
                    1: dir = -1;
                    2: dir = (n < c_RUN || k % 2 == 0) ? 1 : -1;
                    default: dir = (n < c_RUN || $urandom_range(0, 1) == 1) ? 1 : -1;
                endcase
                // random mode: one draw per symbol, reused across its samples
                if (mode == 3 && n >= c_RUN && (n - c_RUN) % c_SPS != 0)
                    dir = (si.size() > 1 &&
                           (si[n-2] * sq[n-1] - sq[n-2] * si[n-1]) < 0) ? -1 : 1;
                ph = ph + dir * step_rad;
            end
            si.push_back($rtoi(amp * $cos(ph) + (($cos(ph) >= 0.0) ? 0.5 : -0.5)));
            sq.push_back($rtoi(amp * $sin(ph) + (($sin(ph) >= 0.0) ? 0.5 : -0.5)));
        end
    endtask

    // Detection: first index ending a run of c_RUN strong samples.
    // Each later group of c_SPS cross products decides one bit by its sign.
    task automatic model();
        int run;
        int acc;
        int cnt;
        exp_bits.delete();
        exp_det = -1;
        run = 0;
        acc = 0;
        cnt = 0;
        for (int n = 0; n < si.size(); n++) begin
            if (exp_det < 0) begin
                run = ((si[n] < 0 ? -si[n] : si[n]) + (sq[n] < 0 ? -sq[n] : sq[n]) > c_THRESH)
                      ? run + 1 : 0;
                if (run == c_RUN) exp_det = n;
            end else if (exp_bits.size() < c_BITS) begin
                acc += si[n-1] * sq[n] - sq[n-1] * si[n];
                cnt++;
                if (cnt == c_SPS) begin
                    exp_bits.push_back(acc >= 0);
                    acc = 0;
                    cnt = 0;
                end
            end
        end
    endtask

    // gaps: 0 none, 1 invalid cycle before every sample, 2 random gaps
    task automatic run_burst(input int gaps);
        got.delete();
        n_done = 0;
        n_fed = 0;
        first_active = -1;
        rx_enable = 1'b0;
        feed(0, 0, 0);
        feed(0, 0, 0);
        rx_enable = 1'b1;
        feed(0, 0, 0);
        for (int n = 0; n < si.size(); n++) begin
            if (gaps == 1 || (gaps == 2 && $urandom_range(0, 2) == 0))
                feed(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 0);
            feed(si[n], sq[n], 1);
        end
        for (int n = 0; n < 4; n++) feed(0, 0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_enable = 1'b0;
        sample_valid = 1'b0;
        in_i = '0;
        in_q = '0;
        step();
        step();
        checks += 5;
        if (bit_out !== 1'b0)      begin errors++; $display("FAIL reset_bit_out got=%0b want=0", bit_out); end
        if (bit_valid !== 1'b0)    begin errors++; $display("FAIL reset_bit_valid got=%0b want=0", bit_valid); end
        if (burst_active !== 1'b0) begin errors++; $display("FAIL reset_burst_active got=%0b want=0", burst_active); end
        if (burst_done !== 1'b0)   begin errors++; $display("FAIL reset_burst_done got=%0b want=0", burst_done); end
        if (bit_count !== 8'd0)    begin errors++; $display("FAIL reset_bit_count got=%0d want=0", bit_count); end
        reset = 1'b0;
    endtask

    task automatic test_rotation(input int mode, input bit want);
        gen_burst(mode, 100, c_RUN + c_BITS * c_SPS);
        run_burst(0);
        checks += 5;
        if (first_active != c_RUN) begin errors++; $display("FAIL rot%0d_detect got=%0d want=%0d", mode, first_active, c_RUN); end
        if (got.size() != c_BITS)  begin errors++; $display("FAIL rot%0d_nbits got=%0d want=%0d", mode, got.size(), c_BITS); end
        if (n_done != 1)           begin errors++; $display("FAIL rot%0d_done got=%0d want=1", mode, n_done); end
        if (bit_count !== 8'(c_BITS)) begin errors++; $display("FAIL rot%0d_count got=%0d want=%0d", mode, bit_count, c_BITS); end
        if (burst_active !== 1'b0) begin errors++; $display("FAIL rot%0d_active_after got=%0b want=0", mode, burst_active); end
        for (int k = 0; k < got.size(); k++) begin
            checks++;
            if (got[k] !== want) begin errors++; $display("FAIL rot%0d_bit%0d got=%0b want=%0b", mode, k, got[k], want); end
        end
    endtask

    task automatic test_low_energy();
        gen_burst(0, 20, 1000);
        run_burst(0);
        checks += 3;
        if (first_active != -1) begin errors++; $display("FAIL low_active got=%0d want=-1", first_active); end
        if (got.size() != 0)    begin errors++; $display("FAIL low_nbits got=%0d want=0", got.size()); end
        if (n_done != 0)        begin errors++; $display("FAIL low_done got=%0d want=0", n_done); end
    endtask

    task automatic test_gaps(input int mode, input int gaps);
        bit ref_bits[$];
        gen_burst(mode, 100, c_RUN + c_BITS * c_SPS);
        model();
        run_burst(0);
        ref_bits = got;
        run_burst(gaps);
        checks += 3;
        if (got.size() != exp_bits.size()) begin errors++; $display("FAIL gap%0d_nbits got=%0d want=%0d", gaps, got.size(), exp_bits.size()); end
        if (bit_count !== 8'(c_BITS)) begin errors++; $display("FAIL gap%0d_count got=%0d want=%0d", gaps, bit_count, c_BITS); end
        if (n_done != 1)              begin errors++; $display("FAIL gap%0d_done got=%0d want=1", gaps, n_done); end
        for (int k = 0; k < got.size() && k < exp_bits.size(); k++) begin
            checks += 2;
            if (got[k] !== exp_bits[k]) begin errors++; $display("FAIL gap%0d_model_bit%0d got=%0b want=%0b", gaps, k, got[k], exp_bits[k]); end
            if (k < ref_bits.size() && got[k] !== ref_bits[k])
                begin errors++; $display("FAIL gap%0d_nogap_bit%0d got=%0b want=%0b", gaps, k, got[k], ref_bits[k]); end
        end
    endtask

    task automatic test_abort();
        int n;
        gen_burst(3, 100, c_RUN + c_BITS * c_SPS);
        model();
        got.delete();
        n_done = 0;
        n_fed = 0;
        first_active = -1;
        rx_enable = 1'b0;
        feed(0, 0, 0);
        rx_enable = 1'b1;
        feed(0, 0, 0);
        n = 0;
        while (got.size() < 50 && n < si.size()) begin
            feed(si[n], sq[n], 1);
            n++;
        end
        rx_enable = 1'b0;
        feed(si[n], sq[n], 1);
        checks += 3;
        if (burst_active !== 1'b0) begin errors++; $display("FAIL abort_active got=%0b want=0", burst_active); end
        if (bit_count !== 8'd50)   begin errors++; $display("FAIL abort_count got=%0d want=50", bit_count); end
        if (got.size() != 50)      begin errors++; $display("FAIL abort_nbits got=%0d want=50", got.size()); end
        for (int k = 0; k < got.size() && k < 50; k++) begin
            checks++;
            if (got[k] !== exp_bits[k]) begin errors++; $display("FAIL abort_bit%0d got=%0b want=%0b", k, got[k], exp_bits[k]); end
        end
        for (int k = 1; k <= 20 && n + k < si.size(); k++) feed(si[n+k], sq[n+k], 1);
        checks += 3;
        if (n_done != 0)         begin errors++; $display("FAIL abort_done got=%0d want=0", n_done); end
        if (got.size() != 50)    begin errors++; $display("FAIL abort_extra_bits got=%0d want=50", got.size()); end
        if (bit_count !== 8'd50) begin errors++; $display("FAIL abort_hold got=%0d want=50", bit_count); end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        gen_burst(0, 100, c_RUN + c_BITS * c_SPS);
        got.delete();
        n_fed = 0;
        rx_enable = 1'b1;
        feed(0, 0, 0);
        n = 0;
        while (got.size() < 10 && n < si.size()) begin
            feed(si[n], sq[n], 1);
            n++;
        end
        reset = 1'b1;
        feed(si[n], sq[n], 1);
        checks += 4;
        if (burst_active !== 1'b0) begin errors++; $display("FAIL midreset_active got=%0b want=0", burst_active); end
        if (bit_count !== 8'd0)    begin errors++; $display("FAIL midreset_count got=%0d want=0", bit_count); end
        if (bit_valid !== 1'b0)    begin errors++; $display("FAIL midreset_valid got=%0b want=0", bit_valid); end
        if (bit_out !== 1'b0)      begin errors++; $display("FAIL midreset_bit_out got=%0b want=0", bit_out); end
        reset = 1'b0;
        test_rotation(0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_rotation(0, 1'b1);
        test_rotation(1, 1'b0);
        test_low_energy();
        test_gaps(2, 1);
        test_gaps(3, 2);
        test_gaps(3, 0);
        test_abort();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
